// File: rtl/riscuva_intc.sv
// Vectored, nesting interrupt controller for the RISCuva core: prioritised channels, mask, nesting stack.
// Optional macro RISCUVA_INTC_EDGE_EN switches request inputs from level to latched rising-edge detection.
module riscuva_intc #(
    parameter int NUM_IRQ    = 4,
    parameter int PC_W       = 10,
    parameter int VEC_BASE   = 1,
    parameter int VEC_STRIDE = 2,
    parameter int NEST_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_IRQ-1:0]            irqReq,
    input  logic                          mayIRQ,
    input  logic                          eiStb,
    input  logic                          diStb,
    input  logic                          retiStb,
    input  logic                          maskWe,
    input  logic [NUM_IRQ-1:0]            maskData,
    output logic                          irqTake,
    output logic                          irqCall,
    output logic [PC_W-1:0]               irqVector,
    output logic [NUM_IRQ-1:0]            irqAck,
    output logic                          userEI,
    output logic [$clog2(NEST_DEPTH):0]   depth,
    output logic                          overflowErr,
    output logic                          underflowErr
);
    localparam int DW = $clog2(NEST_DEPTH) + 1;
    localparam int CW = $clog2(NUM_IRQ + 1);
    localparam int SW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [DW-1:0] DMAX = DW'(NEST_DEPTH);

    logic                 ei_q, call_q, ovf_q, unf_q;
    logic [NUM_IRQ-1:0]   mask_q, ack_q, ack_d;
    logic [DW-1:0]        depth_q, depth_d, top_idx;
    logic [PC_W-1:0]      vec_q;
    logic [CW-1:0]        stack_q [NEST_DEPTH];
    logic [NUM_IRQ-1:0]   src, pend;
    logic [CW-1:0]        win, cur;
    logic [31:0]          vec_full;
    logic                 prio_ok, take, ovf_cond, pop;

`ifdef RISCUVA_INTC_EDGE_EN
    logic [NUM_IRQ-1:0]   req_q, lat_q, lat_d, take_oh;

    // Clearing the taken channel first lets an edge in the same cycle re-arm the latch.
    always_comb begin
        take_oh = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            if (take && CW'(i) == win) take_oh[i] = 1'b1;
        lat_d = (lat_q & ~take_oh) | (irqReq & ~req_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_q <= '0;
            lat_q <= '0;
        end else begin
            req_q <= irqReq;
            lat_q <= lat_d;
        end
    end

    assign src = lat_q;
`else
    assign src = irqReq;
`endif

    assign pend    = src & mask_q & ~ack_q;
    assign top_idx = depth_q - DW'(1);
    assign cur     = (depth_q == '0) ? CW'(NUM_IRQ) : stack_q[top_idx[SW-1:0]];

    always_comb begin
        win = CW'(NUM_IRQ);
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[i]) win = CW'(i);
    end

    assign prio_ok  = (|pend) && (win < cur) && ei_q && mayIRQ;
    assign take     = prio_ok && !retiStb && (depth_q < DMAX);
    assign ovf_cond = prio_ok && (depth_q == DMAX);
    assign pop      = retiStb && (depth_q != '0);
    assign vec_full = 32'(VEC_BASE) + 32'(win) * 32'(VEC_STRIDE);

    always_comb begin
        ack_d   = ack_q;
        depth_d = depth_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (take && CW'(i) == win) ack_d[i] = 1'b1;
            if (pop && CW'(i) == cur)  ack_d[i] = 1'b0;
        end
        if (take)     depth_d = depth_q + DW'(1);
        else if (pop) depth_d = depth_q - DW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ei_q    <= 1'b0;
            mask_q  <= '1;
            ack_q   <= '0;
            depth_q <= '0;
            call_q  <= 1'b0;
            vec_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (diStb)      ei_q <= 1'b0;
            else if (eiStb) ei_q <= 1'b1;
            if (maskWe) mask_q <= maskData;
            ack_q   <= ack_d;
            depth_q <= depth_d;
            call_q  <= take;
            if (take) vec_q <= vec_full[PC_W-1:0];
            if (ovf_cond) ovf_q <= 1'b1;
            if (retiStb && depth_q == '0) unf_q <= 1'b1;
        end
    end

    // Stack contents are only meaningful below depth_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (take) stack_q[depth_q[SW-1:0]] <= win;
    end

    assign irqTake      = take;
    assign irqCall      = call_q;
    assign irqVector    = vec_q;
    assign irqAck       = ack_q;
    assign userEI       = ei_q;
    assign depth        = depth_q;
    assign overflowErr  = ovf_q;
    assign underflowErr = unf_q;
endmodule

// File: doc/riscuva_intc.md
Name: riscuva_intc

Overview:
Parametrised vectored, nesting interrupt controller for the next-generation RISCuva core. It replaces the single-source, non-nesting intReq/intAck/userEI/callingIRQ logic with NUM_IRQ prioritised channels, a per-channel mask and per-channel vectors. It also keeps a nesting stack of active channels so that a higher-priority request can pre-empt a running handler. The core supplies instruction-decode strobes (EI, DI, RETI, mayIRQ) and consumes irqTake, irqCall and irqVector to redirect its PC.

Parameters:
NUM_IRQ, 4, number of request channels (1..8); channel 0 has the highest priority.
PC_W, 10, program address width.
VEC_BASE, 1, vector address of channel 0.
VEC_STRIDE, 2, address distance between consecutive channel vectors.
NEST_DEPTH, 4, maximum number of simultaneously active handlers (power of 2).

Ports:
clk  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-low
irqReq  in  NUM_IRQ  request lines, active-high
mayIRQ  in  1  core can accept an interrupt this cycle
eiStb  in  1  EI instruction strobe
diStb  in  1  DI instruction strobe
retiStb  in  1  RETI instruction strobe
maskWe  in  1  mask register write strobe
maskData  in  NUM_IRQ  new mask value (1 = enabled)
irqTake  out  1  combinational; interrupt accepted this cycle (the core uses it for progReset)
irqCall  out  1  registered irqTake (the core forces the jump and suppresses PC increment)
irqVector  out  PC_W  registered vector for the accepted channel
irqAck  out  NUM_IRQ  per-channel acknowledge, held high until the matching RETI
userEI  out  1  global interrupt enable
depth  out  clog2(NEST_DEPTH)+1  number of active handlers
overflowErr  out  1  sticky error flag
underflowErr  out  1  sticky error flag

Behaviour:
- Reset (reset==0 at a clock edge):
  - userEI=0, mask=all 1s, irqAck=0, depth=0.
  - irqCall=0, irqVector=0.
  - overflowErr=0, underflowErr=0.
  - Nesting stack contents are don't-care.
- Reset asserted mid-handler discards all nesting state; no RETI is required afterwards.
- Global enable:
  - diStb sets userEI=0; eiStb sets userEI=1.
  - If diStb and eiStb are asserted together, DI wins.
  - A change to userEI takes effect from the next cycle.
- Mask: maskWe loads maskData at the clock edge. The new mask is used for arbitration from the next cycle.
- Pending vector: pend = irqReq & mask & ~irqAck.
- Arbitration (combinational):
  - win = lowest set index of pend.
  - cur = channel at the top of the nesting stack; when depth==0, cur = NUM_IRQ (idle).
- irqTake = userEI & mayIRQ & ~retiStb & |pend & (win < cur) & (depth < NEST_DEPTH).
  - Only strictly higher priority pre-empts.
  - RETI blocks a take in the same cycle.
- On irqTake, at the edge:
  - push win onto the stack; depth+1; irqAck[win]=1.
  - irqVector = VEC_BASE + win*VEC_STRIDE, computed modulo 2^PC_W.
  - irqCall=1 for exactly the following cycle.
- irqTake must not assert in the cycle where irqCall=1. The core guarantees this by driving mayIRQ=0 in that cycle.
- On retiStb with depth>0, at the edge: clear irqAck[cur]; pop; depth-1. The previous channel becomes cur again.
- retiStb with depth==0: no state change except underflowErr=1 (sticky).
- The overflow condition is |pend & (win < cur) & userEI & mayIRQ & depth==NEST_DEPTH. When it holds:
  - overflowErr=1 (sticky);
  - no take occurs.
- A channel whose irqAck is set cannot be re-taken until its RETI.
- Latency: request visible → irqTake in the same cycle; irqCall and irqVector valid 1 cycle later.

Optional Feature:
RISCUVA_INTC_EDGE_EN:
- Defined:
  - Each channel registers irqReq and detects a rising edge into a pending latch.
  - pend uses the latch instead of irqReq.
  - The latch is cleared in the same edge as that channel's take.
  - Edges are latched even while the channel is masked or userEI=0.
  - A new edge arriving during take or while acked sets the latch again (one level of queuing).
  - Reset clears all latches and edge registers.
- Undefined: purely level-sensitive as above; no extra registers.

Test Plan:
- Reset, then EI; hold irqReq=4'b0100 with mayIRQ=1 → irqTake pulses once; next cycle irqCall=1, irqVector=10'h005, irqAck=4'b0100, depth=1; no retake while the request is held.
- Channel 2 active; assert irqReq[0] → take with irqVector=10'h001, depth=2. RETI → irqAck=4'b0100, depth=1. RETI → irqAck=0, depth=0.
- Channel 1 active; assert irqReq[3] → no take. RETI → channel 3 taken next eligible cycle, irqVector=10'h007.
- irqReq=4'b0011 with maskWe, maskData=4'b1110 → channel 1 taken, vector 10'h003. diStb and eiStb in the same cycle → userEI=0.
- NEST_DEPTH=2: nest channels 3 then 2, then raise irqReq[0] → no take, overflowErr=1. RETI with depth 0 → underflowErr=1, depth stays 0.
- With RISCUVA_INTC_EDGE_EN defined: 1-cycle pulse on irqReq[1] while userEI=0; then EI → channel 1 taken, latch cleared, no second take.
